mem_axi_arbiter: RTL and testbench

- Shares one AXI3 master port between the icache (line refills) and the dcache (line refills, uncached single reads, write-backs, uncached single writes).
- Sits between the two caches and the core's AXI interface.
- Its grant and stall timing drives the icache_miss and dcache_miss stall inputs of the pipeline hazard control.
- Supports one outstanding read and one outstanding write, which run concurrently.

---
 rtl/arb_defs.sv | 26 ++
 rtl/axi_wr_engine.sv | 112 +++++++++++
 rtl/mem_axi_arbiter.sv | 187 ++++++++++++++++++
 tb/tb_mem_axi_arbiter.sv | 429 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arb_defs.sv
// Shared definitions for the icache/dcache AXI3 arbiter.
// Holds the read and write FSM state encodings, the AXI constants used on the
// master port and the requester IDs placed on arid/awid.
package arb_defs;

  // Read FSM states
  localparam logic [1:0] R_IDLE = 2'd0;
  localparam logic [1:0] R_AR   = 2'd1;
  localparam logic [1:0] R_DATA = 2'd2;

  // Write FSM states
  localparam logic [1:0] W_IDLE = 2'd0;
  localparam logic [1:0] W_AW   = 2'd1;
  localparam logic [1:0] W_DATA = 2'd2;
  localparam logic [1:0] W_RESP = 2'd3;

  // AXI constants
  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [2:0] SIZE_WORD  = 3'b010;
  localparam logic [3:0] STRB_FULL  = 4'hf;

  // Requester IDs
  localparam logic [3:0] ID_ICACHE = 4'd0;
  localparam logic [3:0] ID_DCACHE = 4'd1;

endpackage

// File: rtl/axi_wr_engine.sv
// AXI3 write engine for dcache write-backs and uncached single writes.
// Accepts one write in W_IDLE, latches address/size/strobes and the whole
// line, then issues AW, the W beats (word 0 first) and waits for B.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   wr_req/type/size/addr/strb/data   dcache write request fields
//   wr_rdy                request accepted this cycle
//   wr_done               one-cycle pulse on the B handshake
//   busy                  engine holds an outstanding write
//   aw*/w*/b*             AXI3 write channels (IDs are driven by the top)
module axi_wr_engine
  import arb_defs::*;
#(
  parameter int LINE_WORDS = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    wr_req,
  input  logic                    wr_type,
  input  logic [2:0]              wr_size,
  input  logic [31:0]             wr_addr,
  input  logic [3:0]              wr_strb,
  input  logic [32*LINE_WORDS-1:0] wr_data,
  output logic                    wr_rdy,
  output logic                    wr_done,
  output logic                    busy,
  output logic [31:0]             awaddr,
  output logic [7:0]              awlen,
  output logic [2:0]              awsize,
  output logic [1:0]              awburst,
  output logic                    awvalid,
  input  logic                    awready,
  output logic [31:0]             wdata,
  output logic [3:0]              wstrb,
  output logic                    wlast,
  output logic                    wvalid,
  input  logic                    wready,
  input  logic                    bvalid,
  output logic                    bready
);

  localparam int CNT_W = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      addr_q;
  logic [7:0]       len_q;
  logic [2:0]       size_q;
  logic [3:0]       strb_q;
  logic [31:0]      line_q [LINE_WORDS];
  logic             last_beat;

  assign last_beat = (8'(cnt) == len_q);

  // Control: state and beat counter
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= W_IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        W_IDLE: if (wr_req) state <= W_AW;
        W_AW:   if (awready) state <= W_DATA;
        W_DATA: begin
          if (wready) begin
            if (last_beat) begin
              state <= W_RESP;
              cnt   <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        W_RESP: if (bvalid) state <= W_IDLE;
        default: state <= W_IDLE;
      endcase
    end
  end

  // Data: request fields and line buffer, captured on acceptance
  always_ff @(posedge clk) begin
    if (state == W_IDLE && wr_req) begin
      addr_q <= wr_addr;
      len_q  <= wr_type ? 8'(LINE_WORDS - 1) : 8'd0;
      size_q <= wr_type ? SIZE_WORD : wr_size;
      strb_q <= wr_type ? STRB_FULL : wr_strb;
      for (int i = 0; i < LINE_WORDS; i++) begin
        line_q[i] <= wr_data[32*i +: 32];
      end
    end
  end

  // rdy/done are forced low while reset is held so nothing is accepted or
  // completed during an abandoned transfer.
  assign wr_rdy  = (state == W_IDLE) & ~reset;
  assign wr_done = (state == W_RESP) & bvalid & ~reset;
  assign busy    = (state != W_IDLE);

  assign awaddr  = addr_q;
  assign awlen   = len_q;
  assign awsize  = size_q;
  assign awburst = BURST_INCR;
  assign awvalid = (state == W_AW);

  assign wvalid  = (state == W_DATA);
  assign wdata   = line_q[cnt];
  assign wstrb   = strb_q;
  assign wlast   = wvalid & last_beat;

  assign bready  = (state == W_RESP);

endmodule

// File: rtl/mem_axi_arbiter.sv
// Shares one AXI3 master port between icache refills and dcache traffic.
// Reads: one outstanding, fixed priority dcache over icache; a dcache read
// whose line matches an outstanding write is held until that write completes.
// Writes: delegated to axi_wr_engine, running concurrently with reads.
// Ports:
//   clk, reset               clock, synchronous active-high reset
//   icache_rd_*/icache_ret_* icache line-read request and return beats
//   dcache_rd_*/dcache_ret_* dcache read request and return beats
//   dcache_wr_*              dcache write request, accept and completion
//   ar*/r*/aw*/w*/b*         AXI3 master port
//   perf_*                   optional counters, present with ARB_PERF_EN
// Optional feature macro: ARB_PERF_EN.
module mem_axi_arbiter
  import arb_defs::*;
#(
  parameter int LINE_WORDS = 4,
  parameter int OFFS_W     = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     icache_rd_req,
  input  logic [31:0]              icache_rd_addr,
  output logic                     icache_rd_rdy,
  output logic                     icache_ret_valid,
  output logic                     icache_ret_last,
  output logic [31:0]              icache_ret_data,
  input  logic                     dcache_rd_req,
  input  logic                     dcache_rd_type,
  input  logic [2:0]               dcache_rd_size,
  input  logic [31:0]              dcache_rd_addr,
  output logic                     dcache_rd_rdy,
  output logic                     dcache_ret_valid,
  output logic                     dcache_ret_last,
  output logic [31:0]              dcache_ret_data,
  input  logic                     dcache_wr_req,
  input  logic                     dcache_wr_type,
  input  logic [2:0]               dcache_wr_size,
  input  logic [31:0]              dcache_wr_addr,
  input  logic [3:0]               dcache_wr_strb,
  input  logic [32*LINE_WORDS-1:0] dcache_wr_data,
  output logic                     dcache_wr_rdy,
  output logic                     dcache_wr_done,
  output logic [3:0]               arid,
  output logic [31:0]              araddr,
  output logic [7:0]               arlen,
  output logic [2:0]               arsize,
  output logic [1:0]               arburst,
  output logic                     arvalid,
  input  logic                     arready,
  input  logic [3:0]               rid,
  input  logic [31:0]              rdata,
  input  logic                     rlast,
  input  logic                     rvalid,
  output logic                     rready,
  output logic [3:0]               awid,
  output logic [31:0]              awaddr,
  output logic [7:0]               awlen,
  output logic [2:0]               awsize,
  output logic [1:0]               awburst,
  output logic                     awvalid,
  input  logic                     awready,
  output logic [3:0]               wid,
  output logic [31:0]              wdata,
  output logic [3:0]               wstrb,
  output logic                     wlast,
  output logic                     wvalid,
  input  logic                     wready,
  input  logic                     bvalid,
  output logic                     bready
`ifdef ARB_PERF_EN
  ,
  output logic [31:0]              perf_icache_wait,
  output logic [31:0]              perf_dcache_wait,
  output logic [31:0]              perf_rd_cnt
`endif
);

  logic [1:0]  r_state;
  logic        rd_is_d;
  logic [31:0] ar_addr_q;
  logic [7:0]  arlen_q;
  logic [2:0]  arsize_q;
  logic        wr_busy;
  logic        conflict;
  logic        grant;
  logic        d_single;
  logic        unused;

  // Read responses are routed by the latched requester, so rid is not needed.
  assign unused = ^rid;

  // The compare uses the registered write state: a read arriving in the cycle
  // of dcache_wr_done is still blocked and is granted one cycle later.
  assign conflict = wr_busy & (dcache_rd_addr[31:OFFS_W] == awaddr[31:OFFS_W]);

  assign dcache_rd_rdy = (r_state == R_IDLE) & ~reset & dcache_rd_req & ~conflict;
  assign icache_rd_rdy = (r_state == R_IDLE) & ~reset & icache_rd_req & ~dcache_rd_rdy;
  assign grant         = dcache_rd_rdy | icache_rd_rdy;
  assign d_single      = dcache_rd_rdy & ~dcache_rd_type;

  // Control: read FSM
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= R_IDLE;
    end else begin
      case (r_state)
        R_IDLE: if (grant) r_state <= R_AR;
        R_AR:   if (arready) r_state <= R_DATA;
        R_DATA: if (rvalid && rlast) r_state <= R_IDLE;
        default: r_state <= R_IDLE;
      endcase
    end
  end

  // Data: AR fields and requester, captured on grant
  always_ff @(posedge clk) begin
    if (grant) begin
      rd_is_d   <= dcache_rd_rdy;
      ar_addr_q <= dcache_rd_rdy ? dcache_rd_addr : icache_rd_addr;
      arlen_q   <= d_single ? 8'd0 : 8'(LINE_WORDS - 1);
      arsize_q  <= d_single ? dcache_rd_size : SIZE_WORD;
    end
  end

  assign arid    = rd_is_d ? ID_DCACHE : ID_ICACHE;
  assign araddr  = ar_addr_q;
  assign arlen   = arlen_q;
  assign arsize  = arsize_q;
  assign arburst = BURST_INCR;
  assign arvalid = (r_state == R_AR);
  assign rready  = (r_state == R_DATA);

  assign icache_ret_valid = rready & rvalid & ~rd_is_d;
  assign icache_ret_last  = rlast;
  assign icache_ret_data  = rdata;
  assign dcache_ret_valid = rready & rvalid & rd_is_d;
  assign dcache_ret_last  = rlast;
  assign dcache_ret_data  = rdata;

  assign awid = ID_DCACHE;
  assign wid  = ID_DCACHE;

  axi_wr_engine #(
    .LINE_WORDS (LINE_WORDS)
  ) u_wr (
    .clk     (clk),
    .reset   (reset),
    .wr_req  (dcache_wr_req),
    .wr_type (dcache_wr_type),
    .wr_size (dcache_wr_size),
    .wr_addr (dcache_wr_addr),
    .wr_strb (dcache_wr_strb),
    .wr_data (dcache_wr_data),
    .wr_rdy  (dcache_wr_rdy),
    .wr_done (dcache_wr_done),
    .busy    (wr_busy),
    .awaddr  (awaddr),
    .awlen   (awlen),
    .awsize  (awsize),
    .awburst (awburst),
    .awvalid (awvalid),
    .awready (awready),
    .wdata   (wdata),
    .wstrb   (wstrb),
    .wlast   (wlast),
    .wvalid  (wvalid),
    .wready  (wready),
    .bvalid  (bvalid),
    .bready  (bready)
  );

`ifdef ARB_PERF_EN
  // Control: performance counters, wrapping at 2^32
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_icache_wait <= '0;
      perf_dcache_wait <= '0;
      perf_rd_cnt      <= '0;
    end else begin
      if (icache_rd_req && !icache_rd_rdy) perf_icache_wait <= perf_icache_wait + 32'd1;
      if (dcache_rd_req && !dcache_rd_rdy) perf_dcache_wait <= perf_dcache_wait + 32'd1;
      if (arvalid && arready)              perf_rd_cnt      <= perf_rd_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_axi_arbiter.sv
// Self-checking bench for mem_axi_arbiter: a table of single read grants
// followed by hand-written sequences for priority, write conflicts, AW/W
// ordering, single writes and reset during a read burst.
module tb_mem_axi_arbiter;

  localparam int LW = 4;

  logic         clk, reset;
  logic         icache_rd_req;
  logic [31:0]  icache_rd_addr;
  logic         icache_rd_rdy, icache_ret_valid, icache_ret_last;
  logic [31:0]  icache_ret_data;
  logic         dcache_rd_req, dcache_rd_type;
  logic [2:0]   dcache_rd_size;
  logic [31:0]  dcache_rd_addr;
  logic         dcache_rd_rdy, dcache_ret_valid, dcache_ret_last;
  logic [31:0]  dcache_ret_data;
  logic         dcache_wr_req, dcache_wr_type;
  logic [2:0]   dcache_wr_size;
  logic [31:0]  dcache_wr_addr;
  logic [3:0]   dcache_wr_strb;
  logic [32*LW-1:0] dcache_wr_data;
  logic         dcache_wr_rdy, dcache_wr_done;
  logic [3:0]   arid;
  logic [31:0]  araddr;
  logic [7:0]   arlen;
  logic [2:0]   arsize;
  logic [1:0]   arburst;
  logic         arvalid, arready;
  logic [3:0]   rid;
  logic [31:0]  rdata;
  logic         rlast, rvalid, rready;
  logic [3:0]   awid;
  logic [31:0]  awaddr;
  logic [7:0]   awlen;
  logic [2:0]   awsize;
  logic [1:0]   awburst;
  logic         awvalid, awready;
  logic [3:0]   wid;
  logic [31:0]  wdata;
  logic [3:0]   wstrb;
  logic         wlast, wvalid, wready;
  logic         bvalid, bready;
`ifdef ARB_PERF_EN
  logic [31:0]  perf_icache_wait, perf_dcache_wait, perf_rd_cnt;
`endif

  int total = 0;
  int bad   = 0;

  mem_axi_arbiter #(.LINE_WORDS(LW), .OFFS_W(4)) dut (
    .clk(clk), .reset(reset),
    .icache_rd_req(icache_rd_req), .icache_rd_addr(icache_rd_addr),
    .icache_rd_rdy(icache_rd_rdy), .icache_ret_valid(icache_ret_valid),
    .icache_ret_last(icache_ret_last), .icache_ret_data(icache_ret_data),
    .dcache_rd_req(dcache_rd_req), .dcache_rd_type(dcache_rd_type),
    .dcache_rd_size(dcache_rd_size), .dcache_rd_addr(dcache_rd_addr),
    .dcache_rd_rdy(dcache_rd_rdy), .dcache_ret_valid(dcache_ret_valid),
    .dcache_ret_last(dcache_ret_last), .dcache_ret_data(dcache_ret_data),
    .dcache_wr_req(dcache_wr_req), .dcache_wr_type(dcache_wr_type),
    .dcache_wr_size(dcache_wr_size), .dcache_wr_addr(dcache_wr_addr),
    .dcache_wr_strb(dcache_wr_strb), .dcache_wr_data(dcache_wr_data),
    .dcache_wr_rdy(dcache_wr_rdy), .dcache_wr_done(dcache_wr_done),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
    .arburst(arburst), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
    .awburst(awburst), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .wvalid(wvalid), .wready(wready),
    .bvalid(bvalid), .bready(bready)
`ifdef ARB_PERF_EN
    , .perf_icache_wait(perf_icache_wait), .perf_dcache_wait(perf_dcache_wait),
    .perf_rd_cnt(perf_rd_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        ireq, dreq, dtype;
    logic [2:0]  dsize;
    logic [31:0] iaddr, daddr;
    logic        exp_irdy, exp_drdy;
    logic [3:0]  exp_arid;
    logic [7:0]  exp_arlen;
    logic [2:0]  exp_arsize;
    logic [31:0] exp_araddr;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for arvalid, optionally stall, then complete AR.
  task automatic ar_phase(input int delay);
    int w;
    w = 0;
    while (!arvalid && w < 50) begin
      tick();
      w++;
    end
    chk("ar_seen", 64'(arvalid), 64'd1);
    for (int d = 0; d < delay; d++) tick();
    arready = 1'b1;
    tick();
    arready = 1'b0;
    #1;
    chk("rready_on", 64'(rready), 64'd1);
  endtask

  // Drive n R beats with 'gap' idle cycles before each; count forwarded pulses.
  task automatic r_beats(input bit to_d, input int n, input int gap, input logic [31:0] seed);
    int hits, other;
    hits = 0;
    other = 0;
    for (int b = 0; b < n; b++) begin
      for (int g = 0; g < gap; g++) begin
        rvalid = 1'b0;
        #1;
        if (icache_ret_valid || dcache_ret_valid) other++;
        tick();
      end
      rvalid = 1'b1;
      rlast  = (b == n - 1);
      rdata  = seed + 32'(b);
      #1;
      if (to_d) begin
        if (dcache_ret_valid) hits++;
        if (icache_ret_valid) other++;
        chk("dret_data", 64'(dcache_ret_data), 64'(seed + 32'(b)));
        chk("dret_last", 64'(dcache_ret_last), 64'(b == n - 1));
      end else begin
        if (icache_ret_valid) hits++;
        if (dcache_ret_valid) other++;
        chk("iret_data", 64'(icache_ret_data), 64'(seed + 32'(b)));
        chk("iret_last", 64'(icache_ret_last), 64'(b == n - 1));
      end
      tick();
    end
    rvalid = 1'b0;
    rlast  = 1'b0;
    chk("ret_count", 64'(hits), 64'(n));
    chk("ret_other", 64'(other), 64'd0);
  endtask

  logic [31:0] wexp [4];
  int k, cyc;

  initial begin
    // Grant table: single read requests from idle
    vecs[0] = '{1'b1, 1'b0, 1'b0, 3'd0, 32'h1c000040, 32'h0,
                1'b1, 1'b0, 4'd0, 8'd3, 3'd2, 32'h1c000040};
    vecs[1] = '{1'b0, 1'b1, 1'b1, 3'd0, 32'h0, 32'h00004000,
                1'b0, 1'b1, 4'd1, 8'd3, 3'd2, 32'h00004000};
    vecs[2] = '{1'b0, 1'b1, 1'b0, 3'd0, 32'h0, 32'h00004003,
                1'b0, 1'b1, 4'd1, 8'd0, 3'd0, 32'h00004003};
    vecs[3] = '{1'b1, 1'b1, 1'b0, 3'd1, 32'h1c000100, 32'h00005002,
                1'b0, 1'b1, 4'd1, 8'd0, 3'd1, 32'h00005002};
    vecs[4] = '{1'b0, 1'b1, 1'b0, 3'd2, 32'h0, 32'h00006004,
                1'b0, 1'b1, 4'd1, 8'd0, 3'd2, 32'h00006004};

    reset = 1'b1;
    icache_rd_req = 0; icache_rd_addr = 0;
    dcache_rd_req = 0; dcache_rd_type = 0; dcache_rd_size = 0; dcache_rd_addr = 0;
    dcache_wr_req = 0; dcache_wr_type = 0; dcache_wr_size = 0; dcache_wr_addr = 0;
    dcache_wr_strb = 0; dcache_wr_data = '0;
    arready = 0; rid = 4'd0; rdata = 0; rlast = 0; rvalid = 0;
    awready = 0; wready = 0; bvalid = 0;

    // Reset state (requests held high to show rdy stays low during reset)
    repeat (3) tick();
    icache_rd_req = 1'b1;
    dcache_rd_req = 1'b1;
    #1;
    chk("rst_irdy",   64'(icache_rd_rdy), 64'd0);
    chk("rst_drdy",   64'(dcache_rd_rdy), 64'd0);
    chk("rst_wrdy",   64'(dcache_wr_rdy), 64'd0);
    chk("rst_done",   64'(dcache_wr_done), 64'd0);
    chk("rst_arvalid",64'(arvalid), 64'd0);
    chk("rst_awvalid",64'(awvalid), 64'd0);
    chk("rst_wvalid", 64'(wvalid), 64'd0);
    chk("rst_rready", 64'(rready), 64'd0);
    chk("rst_bready", 64'(bready), 64'd0);
    chk("rst_iret",   64'(icache_ret_valid), 64'd0);
    chk("rst_dret",   64'(dcache_ret_valid), 64'd0);
    icache_rd_req = 1'b0;
    dcache_rd_req = 1'b0;
    reset = 1'b0;
    tick();

    // Table-driven grants
    for (int i = 0; i < 5; i++) begin
      icache_rd_req  = vecs[i].ireq;
      icache_rd_addr = vecs[i].iaddr;
      dcache_rd_req  = vecs[i].dreq;
      dcache_rd_type = vecs[i].dtype;
      dcache_rd_size = vecs[i].dsize;
      dcache_rd_addr = vecs[i].daddr;
      #1;
      chk("vec_irdy", 64'(icache_rd_rdy), 64'(vecs[i].exp_irdy));
      chk("vec_drdy", 64'(dcache_rd_rdy), 64'(vecs[i].exp_drdy));
      tick();
      icache_rd_req = 1'b0;
      dcache_rd_req = 1'b0;
      #1;
      chk("vec_arvalid", 64'(arvalid), 64'd1);
      chk("vec_arid",    64'(arid), 64'(vecs[i].exp_arid));
      chk("vec_arlen",   64'(arlen), 64'(vecs[i].exp_arlen));
      chk("vec_arsize",  64'(arsize), 64'(vecs[i].exp_arsize));
      chk("vec_araddr",  64'(araddr), 64'(vecs[i].exp_araddr));
      chk("vec_arburst", 64'(arburst), 64'd1);
      ar_phase(0);
      r_beats(vecs[i].exp_drdy, int'(vecs[i].exp_arlen) + 1, 0, 32'h100 * 32'(i + 1));
      #1;
      chk("vec_rready_off", 64'(rready), 64'd0);
      tick();
    end

    // Priority: simultaneous line reads, icache held until served
    icache_rd_req = 1'b1; icache_rd_addr = 32'h1c000040;
    dcache_rd_req = 1'b1; dcache_rd_type = 1'b1; dcache_rd_addr = 32'h00008000;
    #1;
    chk("pri_drdy", 64'(dcache_rd_rdy), 64'd1);
    chk("pri_irdy", 64'(icache_rd_rdy), 64'd0);
    tick();
    dcache_rd_req = 1'b0;
    #1;
    chk("pri_arid",  64'(arid), 64'd1);
    chk("pri_arlen", 64'(arlen), 64'd3);
    chk("pri_irdy_busy", 64'(icache_rd_rdy), 64'd0);
    ar_phase(1);
    chk("pri_irdy_data", 64'(icache_rd_rdy), 64'd0);
    r_beats(1'b1, 4, 0, 32'hd0000000);
    #1;
    chk("pri_irdy_after", 64'(icache_rd_rdy), 64'd1);
    tick();
    icache_rd_req = 1'b0;
    #1;
    chk("ic_arid",   64'(arid), 64'd0);
    chk("ic_araddr", 64'(araddr), 64'h1c000040);
    ar_phase(2);
    r_beats(1'b0, 4, 1, 32'h1c000000);

    // Line write then conflicting/non-conflicting reads, AW delay, W toggling
    wexp[0] = 32'ha0a0a0a0; wexp[1] = 32'ha1a1a1a1;
    wexp[2] = 32'ha2a2a2a2; wexp[3] = 32'ha3a3a3a3;
    tick();
    dcache_wr_req  = 1'b1; dcache_wr_type = 1'b1; dcache_wr_size = 3'd0;
    dcache_wr_strb = 4'd0; dcache_wr_addr = 32'h00001230;
    dcache_wr_data = {wexp[3], wexp[2], wexp[1], wexp[0]};
    #1;
    chk("wr_rdy_idle", 64'(dcache_wr_rdy), 64'd1);
    tick();
    dcache_wr_req = 1'b0;
    #1;
    chk("wr_awvalid", 64'(awvalid), 64'd1);
    chk("wr_rdy_busy", 64'(dcache_wr_rdy), 64'd0);
    dcache_rd_req = 1'b1; dcache_rd_type = 1'b0; dcache_rd_size = 3'd2;
    dcache_rd_addr = 32'h00002000;
    #1;
    chk("noconf_drdy", 64'(dcache_rd_rdy), 64'd1);
    tick();
    dcache_rd_req = 1'b0;
    ar_phase(0);
    r_beats(1'b1, 1, 0, 32'h20000000);
    dcache_rd_req = 1'b1; dcache_rd_type = 1'b1; dcache_rd_addr = 32'h00001238;
    #1;
    chk("conf_drdy", 64'(dcache_rd_rdy), 64'd0);
    chk("aw_addr",  64'(awaddr), 64'h00001230);
    chk("aw_len",   64'(awlen), 64'd3);
    chk("aw_size",  64'(awsize), 64'd2);
    chk("aw_burst", 64'(awburst), 64'd1);
    chk("aw_id",    64'(awid), 64'd1);
    for (int d = 0; d < 5; d++) begin
      tick();
      #1;
      chk("no_w_before_aw", 64'(wvalid), 64'd0);
      chk("conf_aw_drdy",   64'(dcache_rd_rdy), 64'd0);
    end
    awready = 1'b1;
    tick();
    awready = 1'b0;
    k = 0;
    cyc = 0;
    while (k < 4 && cyc < 40) begin
      wready = cyc[0];
      #1;
      if (wvalid && wready) begin
        chk("w_data", 64'(wdata), 64'(wexp[k]));
        chk("w_last", 64'(wlast), 64'(k == 3));
        chk("w_strb", 64'(wstrb), 64'hf);
        chk("w_id",   64'(wid), 64'd1);
        k++;
      end
      chk("conf_w_drdy", 64'(dcache_rd_rdy), 64'd0);
      tick();
      cyc++;
    end
    wready = 1'b0;
    chk("w_beats", 64'(k), 64'd4);
    #1;
    chk("resp_bready", 64'(bready), 64'd1);
    chk("resp_wvalid", 64'(wvalid), 64'd0);
    chk("resp_drdy",   64'(dcache_rd_rdy), 64'd0);
    tick();
    bvalid = 1'b1;
    #1;
    chk("wr_done_pulse", 64'(dcache_wr_done), 64'd1);
    chk("done_cyc_drdy", 64'(dcache_rd_rdy), 64'd0);
    tick();
    bvalid = 1'b0;
    #1;
    chk("wr_done_low", 64'(dcache_wr_done), 64'd0);
    chk("bready_off",  64'(bready), 64'd0);
    chk("post_done_drdy", 64'(dcache_rd_rdy), 64'd1);
    tick();
    dcache_rd_req = 1'b0;
    #1;
    chk("raw_araddr", 64'(araddr), 64'h00001238);
    ar_phase(0);
    r_beats(1'b1, 4, 0, 32'h12380000);

    // Uncached single byte write
    tick();
    dcache_wr_req  = 1'b1; dcache_wr_type = 1'b0; dcache_wr_size = 3'd0;
    dcache_wr_strb = 4'b0100; dcache_wr_addr = 32'h00003002;
    dcache_wr_data = 128'hdeadbeef_cafef00d_55667788_11223344;
    #1;
    chk("sw_rdy", 64'(dcache_wr_rdy), 64'd1);
    tick();
    dcache_wr_req = 1'b0;
    #1;
    chk("sw_awvalid", 64'(awvalid), 64'd1);
    chk("sw_awlen",   64'(awlen), 64'd0);
    chk("sw_awsize",  64'(awsize), 64'd0);
    chk("sw_awaddr",  64'(awaddr), 64'h00003002);
    awready = 1'b1;
    tick();
    awready = 1'b0;
    wready  = 1'b1;
    #1;
    chk("sw_wvalid", 64'(wvalid), 64'd1);
    chk("sw_wlast",  64'(wlast), 64'd1);
    chk("sw_wstrb",  64'(wstrb), 64'b0100);
    chk("sw_wdata",  64'(wdata), 64'h11223344);
    tick();
    wready = 1'b0;
    #1;
    chk("sw_wvalid_off", 64'(wvalid), 64'd0);
    chk("sw_bready",     64'(bready), 64'd1);
    bvalid = 1'b1;
    #1;
    chk("sw_done", 64'(dcache_wr_done), 64'd1);
    tick();
    bvalid = 1'b0;

    // Reset during R_DATA beat 2
    icache_rd_req = 1'b1; icache_rd_addr = 32'h1c000080;
    #1;
    chk("rr_irdy", 64'(icache_rd_rdy), 64'd1);
    tick();
    icache_rd_req = 1'b0;
    ar_phase(0);
    for (int b = 0; b < 2; b++) begin
      rvalid = 1'b1; rlast = 1'b0; rdata = 32'h5000 + 32'(b);
      #1;
      chk("rr_pre_beat", 64'(icache_ret_valid), 64'd1);
      tick();
    end
    rvalid = 1'b0;
    reset = 1'b1;
    icache_rd_req = 1'b1;
    tick();
    rvalid = 1'b1;
    rdata = 32'h5002;
    #1;
    chk("rr_rready",  64'(rready), 64'd0);
    chk("rr_arvalid", 64'(arvalid), 64'd0);
    chk("rr_irdy_rst",64'(icache_rd_rdy), 64'd0);
    chk("rr_wrdy_rst",64'(dcache_wr_rdy), 64'd0);
    chk("rr_iret",    64'(icache_ret_valid), 64'd0);
    chk("rr_bready",  64'(bready), 64'd0);
    reset = 1'b0;
    icache_rd_req = 1'b0;
    #1;
    chk("rr_iret_post", 64'(icache_ret_valid), 64'd0);
    tick();
    rlast = 1'b1;
    rdata = 32'h5003;
    #1;
    chk("rr_iret_last", 64'(icache_ret_valid), 64'd0);
    tick();
    rvalid = 1'b0;
    rlast  = 1'b0;
    icache_rd_req = 1'b1; icache_rd_addr = 32'h1c0000c0;
    #1;
    chk("rr_regrant", 64'(icache_rd_rdy), 64'd1);
    tick();
    icache_rd_req = 1'b0;
    #1;
    chk("rr_araddr", 64'(araddr), 64'h1c0000c0);
    ar_phase(0);
    r_beats(1'b0, 4, 0, 32'h1c0c0000);

    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
